input_debounce_2b: RTL and testbench

- Upstream conditioning stage for the 2-bit symbol input of the HW5 dense-state FSM.
- Takes two asynchronous switch/button levels and synchronises each bit through two flops.
- Debounces each bit independently and presents a clean, registered 2-bit code. The FSM samples that code directly as its `in`.
- Also provides a one-cycle change strobe and a stability flag for monitoring.

---
 rtl/input_debounce_2b_pkg.sv | 13 +
 rtl/input_debounce_2b_debounce_bit.sv | 81 ++++++++
 rtl/input_debounce_2b.sv | 49 ++++
 tb/tb_input_debounce_2b.sv | 136 +++++++++++++
 4 files changed

// File: rtl/input_debounce_2b_pkg.sv
// Shared definitions for conditioned-input blocks: per-bit debounce state
// encodings (accepted level is state[1]) and default timing parameters.
package input_debounce_2b_pkg;

  localparam logic [1:0] S_LO   = 2'b00;
  localparam logic [1:0] S_RISE = 2'b01;
  localparam logic [1:0] S_HI   = 2'b11;
  localparam logic [1:0] S_FALL = 2'b10;

  localparam int DB_CYCLES_DEF = 4;
  localparam int CNT_WIDTH_DEF = 3;

endpackage

// File: rtl/input_debounce_2b_debounce_bit.sv
// Single-bit debounce FSM with qualification counter; a new level is accepted
// after DB_CYCLES consecutive opposite-level synchronised samples.
//
// state  | meaning
// S_LO   | accepted low, input agrees
// S_RISE | accepted low, qualifying a high level
// S_HI   | accepted high, input agrees
// S_FALL | accepted high, qualifying a low level
module debounce_bit
  import input_debounce_2b_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic clock,
  input  logic init,
  input  logic d_sync,
  output logic level,
  output logic level_nxt,
  output logic settled
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DB_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [1:0]           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      S_LO: begin
        if (d_sync) begin
          state_nxt = S_RISE;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_RISE: begin
        if (!d_sync) begin
          state_nxt = S_LO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HI;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HI: begin
        if (!d_sync) begin
          state_nxt = S_FALL;
          cnt_nxt   = CNT_ONE;
        end
      end
      default: begin
        if (d_sync) begin
          state_nxt = S_HI;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge init) begin
    if (!init) begin
      state <= S_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // level_nxt lets the parent register a change strobe on the same edge
  assign level     = state[1];
  assign level_nxt = state_nxt[1];
  assign settled   = (state[1] == state[0]);

endmodule

// File: rtl/input_debounce_2b.sv
// 2-bit input conditioner: two-flop synchroniser, per-bit debounce, registered
// change strobe and a settled flag for the downstream FSM's `in` code.
module input_debounce_2b
  import input_debounce_2b_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic       clock,
  input  logic       init,
  input  logic [1:0] raw_in,
  output logic [1:0] in_code,
  output logic       changed,
  output logic       stable
);

  logic [1:0] sync1, sync2;
  logic [1:0] level_nxt;
  logic [1:0] settled;

  always_ff @(posedge clock or negedge init) begin
    if (!init) begin
      sync1   <= 2'b00;
      sync2   <= 2'b00;
      changed <= 1'b0;
    end else begin
      sync1   <= raw_in;
      sync2   <= sync1;
      changed <= |(level_nxt ^ in_code);
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_bit (
      .clock     (clock),
      .init      (init),
      .d_sync    (sync2[i]),
      .level     (in_code[i]),
      .level_nxt (level_nxt[i]),
      .settled   (settled[i])
    );
  end

  assign stable = &settled;

endmodule

// File: tb/tb_input_debounce_2b.sv
// Directed bench for input_debounce_2b: a sample-window reference model pushes
// expected {in_code, changed, stable} per cycle; results are popped after each edge.
module tb_input_debounce_2b;

  localparam int DB = 4;

  logic       clock;
  logic       init;
  logic [1:0] raw_in;
  logic [1:0] in_code;
  logic       changed;
  logic       stable;

  int vectors;
  int miscompares;

  logic [3:0] sb[$];

  logic [1:0]    m_s1, m_s2, m_samp, m_lvl;
  logic          m_chg;
  logic [DB-1:0] m_hist[2];

  input_debounce_2b dut (
    .clock   (clock),
    .init    (init),
    .raw_in  (raw_in),
    .in_code (in_code),
    .changed (changed),
    .stable  (stable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Accept a new level once the last DB synchronised samples all agree.
  task automatic model_edge(input logic [1:0] r, input logic rs);
    logic [1:0] nl;
    if (!rs) begin
      m_s1 = '0; m_s2 = '0; m_samp = '0; m_lvl = '0; m_chg = 1'b0;
      m_hist[0] = '0; m_hist[1] = '0;
    end else begin
      m_samp = m_s2;
      for (int b = 0; b < 2; b++) begin
        m_hist[b] = {m_hist[b][DB-2:0], m_samp[b]};
        if (&m_hist[b]) nl[b] = 1'b1;
        else if (~|m_hist[b]) nl[b] = 1'b0;
        else nl[b] = m_lvl[b];
      end
      m_chg = (nl != m_lvl);
      m_lvl = nl;
      m_s2  = m_s1;
      m_s1  = r;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed {code,chg,stb}=%b expected=%b", tag, $time, obs, exp_v);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic rs, input string tag);
    logic [3:0] e;
    @(negedge clock);
    raw_in = r;
    init   = rs;
    model_edge(r, rs);
    sb.push_back({m_lvl, m_chg, &(m_samp ~^ m_lvl)});
    if (!rs) begin
      #1;
      check({tag, "_async"}, {in_code, changed, stable}, 4'b0001);
    end
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check(tag, {in_code, changed, stable}, e);
  endtask

  task automatic hold(input logic [1:0] r, input int n, input string tag);
    for (int k = 0; k < n; k++) step(r, 1'b1, tag);
  endtask

  initial begin
    logic [1:0] bounce[9];
    int         chg_cnt;
    int         rise_edge;
    vectors     = 0;
    miscompares = 0;
    init        = 1'b0;
    raw_in      = 2'b11;
    m_s1 = '0; m_s2 = '0; m_samp = '0; m_lvl = '0; m_chg = 1'b0;
    m_hist[0] = '0; m_hist[1] = '0;

    for (int k = 0; k < 6; k++) step((k % 2) ? 2'b00 : 2'b11, 1'b0, "reset_hold");
    hold(2'b00, 20, "post_reset_idle");

    // clean rise: change must appear on the 6th edge after the first sample
    rise_edge = -1;
    for (int k = 0; k < 10; k++) begin
      step(2'b10, 1'b1, "clean_rise");
      if (rise_edge < 0 && in_code == 2'b10) rise_edge = k + 1;
    end
    check("rise_latency", 4'(rise_edge), 4'(DB + 2));
    hold(2'b00, 8, "clean_fall");

    hold(2'b01, 3, "glitch_hi");
    hold(2'b00, 8, "glitch_lo");

    bounce = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
    chg_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      step(bounce[k], 1'b1, "bounce");
      chg_cnt += int'(changed);
    end
    for (int k = 0; k < 4; k++) begin
      step(2'b10, 1'b1, "bounce_tail");
      chg_cnt += int'(changed);
    end
    check("bounce_one_pulse", 4'(chg_cnt), 4'd1);
    hold(2'b00, 8, "bounce_release");

    hold(2'b11, 8, "simul_rise");
    hold(2'b00, 8, "simul_fall");

    hold(2'b11, 3, "mid_reset_pre");
    step(2'b11, 1'b0, "mid_reset");
    step(2'b11, 1'b0, "mid_reset");
    hold(2'b11, 10, "mid_reset_post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
